regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32: register data width in bits.
REQ-002 Parameter NREGS, default 32: register count (power of two); AW = log2(NREGS).
REQ-003 Parameter NRD, default 2: number of read ports.
REQ-004 Parameter ZERO_REG, default 1: 1 hardwires register 0 to zero.
REQ-005 Port clk  in  1: single clock; all state updates on rising edge.
REQ-006 Port reset  in  1: asynchronous, active-low reset.
REQ-007 Port rd_addr  in  NRD*AW: packed read addresses, port k at bits [k*AW +: AW].
REQ-008 Port rd_data  out  NRD*XLEN: packed read data, combinational from rd_addr.
REQ-009 Port rd_busy  out  NRD: per-port scoreboard busy bit of the addressed register.
REQ-010 Ports wr0_en / wr1_en  in  1 each: write strobes.
REQ-011 Ports wr0_addr / wr1_addr  in  AW each: write addresses.
REQ-012 Ports wr0_data / wr1_data  in  XLEN each: write data.
REQ-013 Port iss_en  in  1, iss_addr  in  AW: mark destination register busy (instruction issue).
REQ-014 Port clr_req  in  1: request sequential clear of the whole file.
REQ-015 Port clr_busy  out  1: high while the clear sweep runs.
REQ-016 Port clr_done  out  1: one-cycle pulse on the last sweep cycle.

Function
REQ-017 Writes SHALL commit on the rising clk edge when wrN_en=1, in the same cycle.
REQ-018 Same-cycle writes from both ports to one address SHALL store wr1_data (port 1 wins).
REQ-019 With ZERO_REG=1, writes and issues to address 0 SHALL be ignored, and reads of 0 SHALL return 0 with busy 0.
REQ-020 A write on either port SHALL clear the busy bit of its address; iss_en SHALL set the busy bit of iss_addr.
REQ-021 Issue and writeback to the same address in one cycle SHALL leave busy=1 (issue wins).
REQ-022 The FSM SHALL have states IDLE and CLEAR; IDLE->CLEAR on clr_req=1, with the sweep index reset to 0.
REQ-023 In CLEAR, one register per cycle SHALL be zeroed at index 0..NREGS-1; clr_busy=1.
REQ-024 On entry to CLEAR, all busy bits SHALL clear; iss_en and writes SHALL be ignored for the whole sweep.
REQ-025 clr_done SHALL pulse on the cycle index NREGS-1 is zeroed; the FSM then returns to IDLE.
REQ-026 A clear sweep SHALL take exactly NREGS cycles; clr_req during CLEAR SHALL be ignored.
REQ-027 Reads during CLEAR SHALL return the current stored value, zero if already swept.
REQ-028 Address arithmetic SHALL be unsigned AW bits; the sweep index SHALL not wrap past NREGS-1.

Reset
REQ-029 While reset=0: all registers, busy bits and sweep index SHALL be 0; FSM=IDLE; clr_busy=0; clr_done=0.
REQ-030 Reset asserted mid-sweep SHALL abort to IDLE with every register 0 and no clr_done pulse.

Configuration
REQ-031 Macro REGFILE_MP_BYPASS_EN defined: a read addressing a register being written this cycle SHALL return the incoming data (wr1 over wr0) with rd_busy=0.
REQ-032 Macro undefined: such reads SHALL return the old stored value and old busy bit; new data is visible the next cycle.
REQ-033 Bypass SHALL be disabled during CLEAR and for address 0 when ZERO_REG=1.

Structure
REQ-034 Package regfile_pkg SHALL hold the default XLEN/NREGS/NRD constants and the FSM state enum (IDLE, CLEAR).
REQ-035 The busy-bit array and its set/clear priority SHALL live in sub-module regfile_scoreboard.

Verification
REQ-036 Reset, then write wr0 addr 5 = 0xDEADBEEF -> next cycle rd_addr port0=5 returns 0xDEADBEEF.
REQ-037 wr0 and wr1 both to addr 7 (0x1111, 0x2222) -> addr 7 reads 0x2222.
REQ-038 iss addr 3; two cycles later wr1 addr 3 together with iss addr 3 -> rd_busy=1; next writeback alone -> 0.
REQ-039 Write addr 0 = 0xFFFFFFFF with ZERO_REG=1 -> addr 0 reads 0, busy 0.
REQ-040 Fill all regs, pulse clr_req -> clr_busy high 32 cycles, clr_done on cycle 32, all reads 0; a write issued mid-sweep is dropped.
REQ-041 With REGFILE_MP_BYPASS_EN, write addr 9 = 0xA5A5 while reading 9 -> same-cycle 0xA5A5; without the macro -> old value.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and FSM encoding for the multi-port register file.
// Declarations only: no latency, no flow control.
// Consumers import with regfile_pkg::*.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: clear-all > issue set > writeback clear.
// Updates on the clock edge after the request; no backpressure, always accepts.
// Busy vector is a plain flop output, readable combinationally by the caller.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int  NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_all,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr0_en,
  input  logic [AW-1:0]    clr0_addr,
  input  logic             clr1_en,
  input  logic [AW-1:0]    clr1_addr,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] busy_q;

  // Later assignments take priority: issue overrides a same-cycle writeback.
  always_comb begin
    busy_d = busy_q;
    if (clr0_en) busy_d[clr0_addr] = 1'b0;
    if (clr1_en) busy_d[clr1_addr] = 1'b0;
    if (set_en)  busy_d[set_addr]  = 1'b1;
    if (clr_all) busy_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with busy scoreboard and NREGS-cycle clear sweep.
// Reads are combinational, writes commit next edge; REGFILE_MP_BYPASS_EN forwards same-cycle writes.
// No backpressure: writes/issues are silently dropped while the clear sweep runs.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int  XLEN     = XLEN_DEF,
  parameter int  NREGS    = NREGS_DEF,
  parameter int  NRD      = NRD_DEF,
  parameter int  ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr0_en,
  input  logic [AW-1:0]     wr0_addr,
  input  logic [XLEN-1:0]   wr0_data,
  input  logic              wr1_en,
  input  logic [AW-1:0]     wr1_addr,
  input  logic [XLEN-1:0]   wr1_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam bit           ZR       = (ZERO_REG != 0);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy;
  logic            clr_start;
  logic            wr0_ok, wr1_ok, iss_ok;

  assign wr0_ok = (state_q == IDLE) && wr0_en && !(ZR && (wr0_addr == '0));
  assign wr1_ok = (state_q == IDLE) && wr1_en && !(ZR && (wr1_addr == '0));
  assign iss_ok = (state_q == IDLE) && iss_en && !(ZR && (iss_addr == '0));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    clr_start = 1'b0;
    clr_busy  = 1'b0;
    clr_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          idx_d     = '0;
          clr_start = 1'b1;
        end
      end
      CLEAR: begin
        clr_busy = 1'b1;
        if (idx_q == LAST_IDX) begin
          clr_done = 1'b1;
          state_d  = IDLE;
          idx_d    = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Port 1 is applied last so it wins a same-address collision.
  always_comb begin
    regs_d = regs_q;
    if (state_q == CLEAR) begin
      regs_d[idx_q] = '0;
    end else begin
      if (wr0_ok) regs_d[wr0_addr] = wr0_data;
      if (wr1_ok) regs_d[wr1_addr] = wr1_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      regs_q  <= regs_d;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .clr_all   (clr_start),
    .set_en    (iss_ok),
    .set_addr  (iss_addr),
    .clr0_en   (wr0_ok),
    .clr0_addr (wr0_addr),
    .clr1_en   (wr1_ok),
    .clr1_addr (wr1_addr),
    .busy      (busy)
  );

  // wrN_ok already excludes the sweep and register 0, so forwarding inherits both exclusions.
  always_comb begin
    logic [AW-1:0] ra;
    ra      = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = rd_addr[k*AW +: AW];
      if (!(ZR && (ra == '0))) begin
        rd_data[k*XLEN +: XLEN] = regs_q[ra];
        rd_busy[k]              = busy[ra];
`ifdef REGFILE_MP_BYPASS_EN
        if (wr1_ok && (wr1_addr == ra)) begin
          rd_data[k*XLEN +: XLEN] = wr1_data;
          rd_busy[k]              = 1'b0;
        end else if (wr0_ok && (wr0_addr == ra)) begin
          rd_data[k*XLEN +: XLEN] = wr0_data;
          rd_busy[k]              = 1'b0;
        end
`endif
      end
    end
  end

endmodule
